// File: rtl/cray_pkg.sv
// Shared constants and types for the A register file and its scoreboard.
package cray_pkg;
  localparam int A_WIDTH    = 24;
  localparam int A_DEPTH    = 8;
  localparam int A_LOGDEPTH = 3;
  localparam int A_K0_CONST = 1;

  // Read port ordering used for packed per-port buses.
  localparam int NRD  = 4;
  localparam int RD_J = 0;
  localparam int RD_K = 1;
  localparam int RD_I = 2;
  localparam int RD_H = 3;

  // A0 branch condition bundle.
  typedef struct packed {
    logic pos;
    logic neg;
    logic zero;
    logic nzero;
  } a0_cc_t;
endpackage

// File: rtl/a_rsv_scoreboard.sv
// Per-register reservation bits: set on issue, cleared by any returning write.
module a_rsv_scoreboard
  import cray_pkg::*;
#(
  parameter int DEPTH    = A_DEPTH,
  parameter int LOGDEPTH = A_LOGDEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rsv_en,
  input  logic [LOGDEPTH-1:0]           rsv_addr,
  input  logic                          wr0_en,
  input  logic [LOGDEPTH-1:0]           wr0_addr,
  input  logic                          wr1_en,
  input  logic [LOGDEPTH-1:0]           wr1_addr,
  input  logic [NRD-1:0][LOGDEPTH-1:0]  rd_addr,
  output logic [NRD-1:0]                busy,
  output logic                          rsv_err
);
  logic [DEPTH-1:0] rsv_q;
  logic [DEPTH-1:0] clr;
  logic [DEPTH-1:0] set;

  // Decode clear (any enabled write, dropped wr1 included) and set vectors.
  always_comb begin
    clr = '0;
    set = '0;
    for (int r = 0; r < DEPTH; r++) begin
      clr[r] = (wr0_en && (wr0_addr == LOGDEPTH'(r))) ||
               (wr1_en && (wr1_addr == LOGDEPTH'(r)));
      set[r] = rsv_en && (rsv_addr == LOGDEPTH'(r));
    end
  end

  // Reservation state; a same-cycle reserve beats the clearing write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsv_q   <= '0;
      rsv_err <= 1'b0;
    end else begin
      rsv_q   <= set | (rsv_q & ~clr);
      rsv_err <= rsv_en && rsv_q[rsv_addr] && !clr[rsv_addr];
    end
  end

  // Busy masks out a result arriving this cycle so data and busy agree.
  always_comb begin
    busy = '0;
    for (int p = 0; p < NRD; p++)
      busy[p] = rsv_q[rd_addr[p]] && !clr[rd_addr[p]];
  end
endmodule

// File: rtl/a_regfile_rsv.sv
// A register file: two write ports, four bypassed read ports, A0 flags,
// reservation scoreboard for issue-time hazard checks.
module a_regfile_rsv
  import cray_pkg::*;
#(
  parameter int WIDTH    = A_WIDTH,
  parameter int DEPTH    = A_DEPTH,
  parameter int LOGDEPTH = A_LOGDEPTH,
  parameter int K0_CONST = A_K0_CONST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LOGDEPTH-1:0] i_j_addr,
  input  logic [LOGDEPTH-1:0] i_k_addr,
  input  logic [LOGDEPTH-1:0] i_i_addr,
  input  logic [LOGDEPTH-1:0] i_h_addr,
  output logic [WIDTH-1:0]    o_j_data,
  output logic [WIDTH-1:0]    o_k_data,
  output logic [WIDTH-1:0]    o_i_data,
  output logic [WIDTH-1:0]    o_h_data,
  output logic                o_j_busy,
  output logic                o_k_busy,
  output logic                o_i_busy,
  output logic                o_h_busy,
  input  logic                i_rsv_en,
  input  logic [LOGDEPTH-1:0] i_rsv_addr,
  input  logic                i_wr0_en,
  input  logic [LOGDEPTH-1:0] i_wr0_addr,
  input  logic [WIDTH-1:0]    i_wr0_data,
  input  logic                i_wr1_en,
  input  logic [LOGDEPTH-1:0] i_wr1_addr,
  input  logic [WIDTH-1:0]    i_wr1_data,
  output logic [WIDTH-1:0]    o_a0_data,
  output logic                o_a0_pos,
  output logic                o_a0_neg,
  output logic                o_a0_zero,
  output logic                o_a0_nzero,
  output logic                o_wr_collision,
  output logic                o_rsv_err
);
  localparam logic [WIDTH-1:0] K0 = WIDTH'(K0_CONST);

  logic [DEPTH-1:0][WIDTH-1:0]  regs;
  logic                         coll;
  logic                         wr1_live;
  logic [NRD-1:0][LOGDEPTH-1:0] rd_addr;
  logic [NRD-1:0][WIDTH-1:0]    rd_data;
  logic [NRD-1:0]               rd_busy;
  a0_cc_t                       a0_cc;

  assign coll     = i_wr0_en && i_wr1_en && (i_wr0_addr == i_wr1_addr);
  assign wr1_live = i_wr1_en && !coll;

  // Array write; wr0 wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (wr1_live) regs[i_wr1_addr] <= i_wr1_data;
      if (i_wr0_en) regs[i_wr0_addr] <= i_wr0_data;
    end
  end

  // Collision flag pulses for the cycle after the clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_wr_collision <= 1'b0;
    else        o_wr_collision <= coll;
  end

  assign rd_addr[RD_J] = i_j_addr;
  assign rd_addr[RD_K] = i_k_addr;
  assign rd_addr[RD_I] = i_i_addr;
  assign rd_addr[RD_H] = i_h_addr;

  // Per-port bypass mux; bypass outranks the register-0 special cases.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    always_comb begin
      rd_data[p] = regs[rd_addr[p]];
      if (i_wr0_en && (i_wr0_addr == rd_addr[p]))
        rd_data[p] = i_wr0_data;
      else if (i_wr1_en && (i_wr1_addr == rd_addr[p]))
        rd_data[p] = i_wr1_data;
      else if (rd_addr[p] == '0) begin
        if (p == RD_K)      rd_data[p] = K0;
        else if (p != RD_I) rd_data[p] = '0;
      end
    end
  end

  assign o_j_data = rd_data[RD_J];
  assign o_k_data = rd_data[RD_K];
  assign o_i_data = rd_data[RD_I];
  assign o_h_data = rd_data[RD_H];

  // A0 uses the same bypass, but always the true register 0.
  always_comb begin
    o_a0_data = regs[0];
    if (i_wr0_en && (i_wr0_addr == '0))      o_a0_data = i_wr0_data;
    else if (i_wr1_en && (i_wr1_addr == '0)) o_a0_data = i_wr1_data;
  end

  // Branch condition codes from the bypassed A0 value.
  always_comb begin
    a0_cc.neg   = o_a0_data[WIDTH-1];
    a0_cc.pos   = !o_a0_data[WIDTH-1];
    a0_cc.zero  = (o_a0_data == '0);
    a0_cc.nzero = (o_a0_data != '0);
  end

  assign o_a0_pos   = a0_cc.pos;
  assign o_a0_neg   = a0_cc.neg;
  assign o_a0_zero  = a0_cc.zero;
  assign o_a0_nzero = a0_cc.nzero;

  a_rsv_scoreboard #(
    .DEPTH    (DEPTH),
    .LOGDEPTH (LOGDEPTH)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (i_rsv_en),
    .rsv_addr (i_rsv_addr),
    .wr0_en   (i_wr0_en),
    .wr0_addr (i_wr0_addr),
    .wr1_en   (i_wr1_en),
    .wr1_addr (i_wr1_addr),
    .rd_addr  (rd_addr),
    .busy     (rd_busy),
    .rsv_err  (o_rsv_err)
  );

  assign o_j_busy = rd_busy[RD_J];
  assign o_k_busy = rd_busy[RD_K];
  assign o_i_busy = rd_busy[RD_I];
  assign o_h_busy = rd_busy[RD_H];
endmodule

// File: tb/tb_a_regfile_rsv.sv
// Bench for a_regfile_rsv: behavioural model plus directed and random stimulus.
module tb_a_regfile_rsv;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]  j_a, k_a, i_a, h_a, rsv_a, w0a, w1a;
  logic        rsv_en, w0e, w1e;
  logic [23:0] w0d, w1d;
  logic [23:0] j_d, k_d, i_d, h_d, a0_d;
  logic        j_b, k_b, i_b, h_b, a0_pos, a0_neg, a0_zero, a0_nzero, coll_o, err_o;

  always #5 clk = ~clk;

  a_regfile_rsv dut (
    .clk(clk), .rst_n(rst_n),
    .i_j_addr(j_a), .i_k_addr(k_a), .i_i_addr(i_a), .i_h_addr(h_a),
    .o_j_data(j_d), .o_k_data(k_d), .o_i_data(i_d), .o_h_data(h_d),
    .o_j_busy(j_b), .o_k_busy(k_b), .o_i_busy(i_b), .o_h_busy(h_b),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_a),
    .i_wr0_en(w0e), .i_wr0_addr(w0a), .i_wr0_data(w0d),
    .i_wr1_en(w1e), .i_wr1_addr(w1a), .i_wr1_data(w1d),
    .o_a0_data(a0_d), .o_a0_pos(a0_pos), .o_a0_neg(a0_neg),
    .o_a0_zero(a0_zero), .o_a0_nzero(a0_nzero),
    .o_wr_collision(coll_o), .o_rsv_err(err_o)
  );

  // Model state
  logic [23:0] m_reg [8];
  logic        m_rsv [8];
  logic        m_coll, m_err;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] m_read(int port, logic [2:0] a);
    if (w0e && w0a == a) return w0d;
    if (w1e && w1a == a) return w1d;
    if (a == 0) begin
      if (port == 1) return 24'd1;
      if (port == 2) return m_reg[0];
      return 24'd0;
    end
    return m_reg[a];
  endfunction

  function automatic logic written(logic [2:0] a);
    return (w0e && w0a == a) || (w1e && w1a == a);
  endfunction

  function automatic logic m_busy(logic [2:0] a);
    return m_rsv[a] && !written(a);
  endfunction

  task automatic check_all();
    logic [23:0] a0;
    a0 = (w0e && w0a == 0) ? w0d : (w1e && w1a == 0) ? w1d : m_reg[0];
    chk("j_data", 32'(j_d), 32'(m_read(0, j_a)));
    chk("k_data", 32'(k_d), 32'(m_read(1, k_a)));
    chk("i_data", 32'(i_d), 32'(m_read(2, i_a)));
    chk("h_data", 32'(h_d), 32'(m_read(3, h_a)));
    chk("j_busy", 32'(j_b), 32'(m_busy(j_a)));
    chk("k_busy", 32'(k_b), 32'(m_busy(k_a)));
    chk("i_busy", 32'(i_b), 32'(m_busy(i_a)));
    chk("h_busy", 32'(h_b), 32'(m_busy(h_a)));
    chk("a0_data", 32'(a0_d), 32'(a0));
    chk("a0_pos", 32'(a0_pos), 32'(!a0[23]));
    chk("a0_neg", 32'(a0_neg), 32'(a0[23]));
    chk("a0_zero", 32'(a0_zero), 32'(a0 == 0));
    chk("a0_nzero", 32'(a0_nzero), 32'(a0 != 0));
    chk("wr_collision", 32'(coll_o), 32'(m_coll));
    chk("rsv_err", 32'(err_o), 32'(m_err));
  endtask

  task automatic m_reset();
    for (int r = 0; r < 8; r++) begin m_reg[r] = 0; m_rsv[r] = 0; end
    m_coll = 0; m_err = 0;
  endtask

  task automatic m_update();
    logic c;
    c = w0e && w1e && (w0a == w1a);
    m_coll = c;
    m_err  = rsv_en && m_rsv[rsv_a] && !written(rsv_a);
    if (w1e && !c) m_reg[w1a] = w1d;
    if (w0e) m_reg[w0a] = w0d;
    if (w0e) m_rsv[w0a] = 0;
    if (w1e) m_rsv[w1a] = 0;
    if (rsv_en) m_rsv[rsv_a] = 1;
  endtask

  task automatic idle();
    j_a = 0; k_a = 0; i_a = 0; h_a = 0;
    rsv_en = 0; rsv_a = 0;
    w0e = 0; w0a = 0; w0d = 0;
    w1e = 0; w1a = 0; w1d = 0;
  endtask

  // Inputs settle after negedge; compare, then advance model at posedge.
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  initial begin
    idle();
    m_reset();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    idle();
    #1;
    chk("rst_k0", 32'(k_d), 32'h1);
    chk("rst_j0", 32'(j_d), 32'h0);
    chk("rst_a0_zero", 32'(a0_zero), 32'h1);
    chk("rst_a0_pos", 32'(a0_pos), 32'h1);
    tick();

    // Write bypass and persistence
    w0e = 1; w0a = 3; w0d = 24'h800000; j_a = 3;
    #1 chk("byp_j3", 32'(j_d), 32'h800000);
    tick();
    idle(); j_a = 3;
    #1 chk("hold_j3", 32'(j_d), 32'h800000);
    tick();
    w0e = 1; w0a = 0; w0d = 24'h800000;
    #1 chk("a0_neg_byp", 32'(a0_neg), 32'h1);
    chk("a0_nzero_byp", 32'(a0_nzero), 32'h1);
    tick();

    // Reserve then return on wr1
    idle(); rsv_en = 1; rsv_a = 5;
    tick();
    idle(); i_a = 5;
    #1 chk("busy5", 32'(i_b), 32'h1);
    tick();
    w1e = 1; w1a = 5; w1d = 24'h00ABCD; i_a = 5;
    #1 chk("ret_busy5", 32'(i_b), 32'h0);
    chk("ret_data5", 32'(i_d), 32'h00ABCD);
    tick();
    idle(); i_a = 5;
    #1 chk("clr5", 32'(i_b), 32'h0);
    tick();

    // Write collision
    w0e = 1; w0a = 2; w0d = 24'h111111;
    w1e = 1; w1a = 2; w1d = 24'h222222;
    tick();
    idle(); j_a = 2;
    #1 chk("coll_pulse", 32'(coll_o), 32'h1);
    chk("coll_data", 32'(j_d), 32'h111111);
    tick();
    idle();
    #1 chk("coll_gone", 32'(coll_o), 32'h0);
    tick();

    // Double reserve and reserve-with-write
    rsv_en = 1; rsv_a = 4; tick();
    rsv_en = 1; rsv_a = 4; tick();
    idle(); h_a = 4;
    #1 chk("rsv_err_pulse", 32'(err_o), 32'h1);
    chk("rsv4_still", 32'(h_b), 32'h1);
    tick();
    h_a = 4;
    #1 chk("rsv_err_gone", 32'(err_o), 32'h0);
    tick();
    rsv_en = 1; rsv_a = 4; w0e = 1; w0a = 4; w0d = 24'h55AA55;
    tick();
    idle(); h_a = 4;
    #1 chk("rsvwr_noerr", 32'(err_o), 32'h0);
    chk("rsvwr_busy", 32'(h_b), 32'h1);
    chk("rsvwr_data", 32'(h_d), 32'h55AA55);
    tick();

    // Asynchronous reset between edges
    rsv_en = 1; rsv_a = 1; tick();
    rsv_en = 1; rsv_a = 6; w0e = 1; w0a = 6; w0d = 24'h123456; tick();
    idle(); i_a = 1; h_a = 6;
    #1 chk("pre_rst_b1", 32'(i_b), 32'h1);
    chk("pre_rst_b6", 32'(h_b), 32'h1);
    #1 rst_n = 1'b0;
    m_reset();
    #1 chk("arst_b1", 32'(i_b), 32'h0);
    chk("arst_d6", 32'(h_d), 32'h0);
    check_all();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(); i_a = 1; h_a = 6;
    tick();
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      j_a = 3'($urandom_range(0, 7)); k_a = 3'($urandom_range(0, 7));
      i_a = 3'($urandom_range(0, 7)); h_a = 3'($urandom_range(0, 7));
      rsv_en = ($urandom_range(0, 2) == 0); rsv_a = 3'($urandom_range(0, 7));
      w0e = ($urandom_range(0, 2) == 0); w0a = 3'($urandom_range(0, 7));
      w1e = ($urandom_range(0, 2) == 0); w1a = 3'($urandom_range(0, 7));
      w0d = 24'($urandom); w1d = 24'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/a_regfile_rsv.md
Name: a_regfile_rsv

Overview:
- Parametrised successor to the 8-entry, 24-bit address register file.
- Adds a per-register reservation scoreboard for issue-time hazard checks.
- Adds two write ports: wr0 for the issue/transmit path and wr1 for functional-unit and memory return.
- Keeps four bypassed read ports, the j/k special cases for register 0, the A0 branch flags and registered error flags; sits between instruction issue and the address functional units.

Parameters:
- WIDTH, 24, register width in bits.
- DEPTH, 8, number of registers.
- LOGDEPTH, 3, address width; must equal clog2(DEPTH).
- K0_CONST, 1, value returned on the k port when k address is 0.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_j_addr / i_k_addr / i_i_addr / i_h_addr  in  LOGDEPTH  read port addresses.
- o_j_data / o_k_data / o_i_data / o_h_data  out  WIDTH  read port data (combinational).
- o_j_busy / o_k_busy / o_i_busy / o_h_busy  out  1  addressed register has an outstanding reservation.
- i_rsv_en  in  1  reserve the destination register at issue.
- i_rsv_addr  in  LOGDEPTH  register to reserve.
- i_wr0_en / i_wr0_addr / i_wr0_data  in  1 / LOGDEPTH / WIDTH  write port 0 (higher priority).
- i_wr1_en / i_wr1_addr / i_wr1_data  in  1 / LOGDEPTH / WIDTH  write port 1.
- o_a0_data  out  WIDTH  bypassed contents of register 0.
- o_a0_pos / o_a0_neg / o_a0_zero / o_a0_nzero  out  1  branch conditions derived from o_a0_data.
- o_wr_collision  out  1  registered: wr0 and wr1 targeted the same address in the previous cycle.
- o_rsv_err  out  1  registered: the previous cycle reserved an already-reserved register with no clearing write.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all reservation bits 0, o_wr_collision 0, o_rsv_err 0.
  - Consequently o_a0_data = 0, o_a0_zero = 1, o_a0_pos = 1, o_a0_neg = 0, o_a0_nzero = 0, all busy outputs 0.
  - Reset mid-operation discards every pending reservation; writes in the reset cycle are lost.
- Writes:
  - Take effect at the rising edge when the enable is high.
  - If wr0 and wr1 are enabled to the same address, wr0 data is written, wr1 is dropped, and o_wr_collision = 1 on the next cycle for exactly one cycle.
  - Different addresses: both writes occur.
- Read ports, same-cycle bypass (combinational):
  - Address matches an enabled wr0 → i_wr0_data.
  - Else address matches an enabled wr1 → i_wr1_data.
  - Else the array entry.
  - Bypass has priority over the register-0 special cases.
  - With no bypass: j and h ports return 0 for address 0; k port returns K0_CONST zero-extended to WIDTH; i port returns the true register 0.
- A0 outputs: o_a0_data is register 0 with the same wr0/wr1 bypass as the read ports.
  - o_a0_neg = MSB of o_a0_data; o_a0_pos = its inverse.
  - o_a0_zero = (o_a0_data == 0); o_a0_nzero = its inverse.
- Reservation scoreboard, one bit per register:
  - Set at the edge when i_rsv_en is high.
  - Cleared at the edge by any enabled write (wr0 or wr1, including a dropped wr1) to that address.
  - Reserve and write to the same address in one cycle: reservation wins, bit ends set, write data still stored.
- Busy outputs: busy = rsv_bit[addr] AND NOT (enabled write to addr this cycle). Data and busy for a returning result are therefore consistent in the same cycle.
- o_rsv_err = 1 on the cycle after i_rsv_en targets a register whose bit is set and no write clears it in that same cycle; one-cycle pulse. The reservation remains set.
- There is no read latency; write-to-array latency is 1 cycle; scoreboard update latency is 1 cycle.

Decomposition:
- Shared package (cray_pkg): A_WIDTH = 24, A_DEPTH = 8, A_LOGDEPTH = 3, K0_CONST default, and the A0 condition-code bundle type (pos/neg/zero/nzero).
- One natural sub-module: a_rsv_scoreboard, holding the DEPTH reservation bits, set/clear priority logic, busy lookup per read port, and o_rsv_err generation.
- The data array, bypass muxes and A0 flags remain in a_regfile_rsv.

Test Plan:
1. Reset then idle → all data ports 0 except k port at address 0 = 1; o_a0_zero = 1, o_a0_pos = 1; all busy 0; both error flags 0.
2. wr0 addr 3 = 0x800000, j_addr = 3 in the same cycle → o_j_data = 0x800000 that cycle and after. Same via addr 0 → o_a0_neg = 1, o_a0_nzero = 1.
3. rsv addr 5 → o_i_busy (i_addr = 5) = 1 from the next cycle. wr1 addr 5 = 0x00ABCD → same cycle busy = 0, data = 0x00ABCD; next cycle rsv bit clear.
4. wr0 addr 2 = 0x111111 and wr1 addr 2 = 0x222222 in one cycle → register 2 = 0x111111; o_wr_collision = 1 for exactly one cycle.
5. rsv addr 4 twice back-to-back → o_rsv_err = 1 one cycle after the second reserve, bit still set. rsv addr 4 with simultaneous wr0 to 4 → no error, bit set, data stored.
6. Assert rst_n low asynchronously between edges with rsv bits 1 and 6 set → busy outputs drop immediately, registers read 0, no error pulses after release.
